// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: state encoding and default widths.
package counter_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_REP_W = 4;

    // Controller phases; the numeric values are visible on state_q in waveforms.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/counter_sequencer_seq_counter.sv
// Loadable up-counter with enable and an equality compare against an external value.
// Load has priority over enable; the count wraps naturally at 2^WIDTH.
module seq_counter
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] cnt,
    output logic             eq
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins, otherwise increment when enabled, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign eq  = (cnt_q == cmp_val);

endmodule

// File: rtl/counter_sequencer.sv
// Sequences a loadable up-counter through programmed runs: each interval counts
// from the captured start value to the captured limit, reloading until the
// repeat count is exhausted (reps=0 free-runs until abort).
//
// Handshake: start is a level request honoured only in IDLE and only when abort
// is low; once accepted, inputs are captured and further starts are ignored until
// the controller is back in IDLE. abort is honoured only in RUN and takes effect
// at the next clock edge. tick and done are single-cycle pulses with no back-pressure.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int REP_W = DEFAULT_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] limit,
    input  logic [REP_W-1:0] reps,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [WIDTH-1:0] cnt,
    output logic [REP_W-1:0] rep_left
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] start_r_q;
    logic [WIDTH-1:0] start_r_d;
    logic [WIDTH-1:0] limit_r_q;
    logic [WIDTH-1:0] limit_r_d;
    logic [REP_W-1:0] rep_left_q;
    logic [REP_W-1:0] rep_left_d;

    logic             ctr_load;
    logic             ctr_en;
    logic [WIDTH-1:0] ctr_load_val;
    logic             cnt_eq;

    seq_counter #(
        .WIDTH (WIDTH)
    ) u_seq_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .en       (ctr_en),
        .load_val (ctr_load_val),
        .cmp_val  (limit_r_q),
        .cnt      (cnt),
        .eq       (cnt_eq)
    );

    // Next-state, capture and counter-control decode.
    always_comb begin
        state_d      = state_q;
        start_r_d    = start_r_q;
        limit_r_d    = limit_r_q;
        rep_left_d   = rep_left_q;
        ctr_load     = 1'b0;
        ctr_en       = 1'b0;
        ctr_load_val = start_r_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    start_r_d    = start_val;
                    limit_r_d    = limit;
                    rep_left_d   = reps;
                    ctr_load     = 1'b1;
                    ctr_load_val = start_val;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_eq) begin
                    if (rep_left_q == REP_W'(1)) begin
                        // Final interval: counter holds at the limit.
                        state_d = S_DONE;
                    end else begin
                        ctr_load = 1'b1;
                        if (rep_left_q != '0) begin
                            rep_left_d = rep_left_q - REP_W'(1);
                        end
                    end
                end else begin
                    ctr_en = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller state and captured run parameters, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            start_r_q  <= '0;
            limit_r_q  <= '0;
            rep_left_q <= '0;
        end else begin
            state_q    <= state_d;
            start_r_q  <= start_r_d;
            limit_r_q  <= limit_r_d;
            rep_left_q <= rep_left_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign tick     = (state_q == S_RUN) && cnt_eq && !abort;
    assign rep_left = rep_left_q;

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Controller that sequences a loadable up-counter with terminal-count detection through programmed timing runs. On `start` it captures a start value, a limit and a repeat count. It then drives the counter from the start value to the limit. Each time the limit is reached it reloads the start value, until the repeat count is exhausted. It sits between a host or FSM that requests timed intervals and the counter datapath, and reports per-interval ticks and a completion pulse.

Parameters:
WIDTH, 4, counter/start/limit width in bits
REP_W, 4, width of repeat-count field

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request a run; sampled only in IDLE
abort  input  1  terminate an active run; sampled in RUN
start_val  input  WIDTH  counter load value, captured on accepted start
limit  input  WIDTH  terminal value, captured on accepted start
reps  input  REP_W  interval count; 0 = free-run until abort
busy  output  1  high while in RUN
tick  output  1  one-cycle pulse when cnt equals captured limit in RUN
done  output  1  one-cycle pulse after final interval completes
cnt  output  WIDTH  current counter value
rep_left  output  REP_W  intervals remaining, including the current one

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, rep_left=0, captured start_val/limit/reps=0, busy=0, tick=0, done=0. Reset mid-run abandons the run with no done pulse.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - On an edge with start=1 and abort=0: capture start_val, limit and reps; cnt<=start_val; rep_left<=reps; go to RUN.
  - start=1 and abort=1 in the same cycle: abort wins, stay IDLE.
  - cnt holds its last value while in IDLE.
- RUN:
  - busy=1.
  - tick is combinational: (state==RUN) & (cnt==limit_r) & ~abort.
  - On each edge, evaluate in priority order:
    1. abort=1: go to IDLE, cnt holds, no tick, no done.
    2. tick and rep_left==1: go to DONE, cnt holds at limit.
    3. tick, otherwise: cnt<=start_val_r; rep_left decrements unless rep_left==0 (free-run).
    4. Else: cnt<=cnt+1 mod 2^WIDTH.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE unconditionally. A start asserted during DONE is ignored.
- start while busy is ignored; captured values cannot change mid-run.
- Interval length in cycles = ((limit - start_val) mod 2^WIDTH) + 1.
  - start_val == limit: tick on the first RUN cycle.
  - start_val > limit: counter wraps from 2^WIDTH-1 to 0 and continues up to limit.
- Latency: cnt=start_val is visible the cycle after start is accepted. done is asserted the cycle after the final tick.
- Total run length for N reps = N*interval RUN cycles + 1 DONE cycle.
- All outputs except tick are registered or state-decoded.

Decomposition:
- Shared include/package: state encoding localparams (S_IDLE=0, S_RUN=1, S_DONE=2); default WIDTH/REP_W constants.
- One sub-module is natural: seq_counter.
  - Function: WIDTH-bit loadable up-counter with enable, load, load value, compare value and equality output.
  - The controller drives load/enable and consumes the equality output as tick.

Test Plan:
- Reset mid-run: rst pulse asynchronously while cnt=3 in RUN -> busy, tick, done and cnt drop to 0 immediately, no clock edge required; state IDLE.
- Basic run, start_val=2, limit=5, reps=1: cnt=2,3,4,5 on cycles 1-4 after start; tick on cycle 4; done on cycle 5; busy low from cycle 5.
- Repeat run, start_val=0, limit=2, reps=3: ticks at cycles 3, 6 and 9; rep_left goes 3→2→1; cnt reloads 0 after each tick; single done at cycle 10.
- Wrap and equal boundaries:
  - start_val=14, limit=1, reps=1 (WIDTH=4): cnt 14,15,0,1; tick on 4th RUN cycle.
  - start_val=limit=7: tick on 1st RUN cycle, done next cycle.
- Abort and free-run, reps=0, start_val=0, limit=3: ticks every 4 cycles indefinitely, rep_left stays 0. Assert abort in the same cycle cnt=3 -> no tick, next cycle IDLE, busy=0, done never asserted.
- Start collisions:
  - start held high through RUN and DONE -> no recapture until IDLE; new run begins the cycle after returning to IDLE.
  - start=abort=1 in IDLE -> stays IDLE.
